// File: rtl/branch_resolve_queue.sv
// Branch resolve queue: tracks in-flight conditional branches in fetch order,
// retires the oldest when execute resolves it, emits a registered predictor
// update and, on a wrong prediction, a one-cycle redirect pulse plus a flush.
module branch_resolve_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [15:0] push_pc,
  input  logic        push_pred,
  input  logic        resolve,
  input  logic        resolve_taken,
  input  logic [15:0] resolve_target,
  output logic        full,
  output logic        empty,
  output logic [3:0]  count,
  output logic        upd_load,
  output logic [15:0] upd_pc,
  output logic        upd_branched,
  output logic        mispredict,
  output logic [15:0] redirect_pc
);

  localparam int unsigned PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  DepthCnt = 4'(DEPTH);

  // Entry storage; DEPTH is a power of two so pointers wrap by overflow.
  logic [15:0]      pc_q   [DEPTH];
  logic [DEPTH-1:0] pred_q;

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [3:0]      occ_q, occ_d;

  logic        upd_load_q, upd_load_d;
  logic [15:0] upd_pc_q, upd_pc_d;
  logic        upd_branched_q, upd_branched_d;
  logic        mispredict_q, mispredict_d;
  logic [15:0] redirect_pc_q, redirect_pc_d;

  logic [15:0] head_pc;
  logic        head_pred;
  logic        resolve_ok;
  logic        mis;
  logic        push_ok;

  assign head_pc   = pc_q[head_q];
  assign head_pred = pred_q[head_q];

  // Status comes straight from registered occupancy; no push-to-resolve bypass.
  assign full  = (occ_q == DepthCnt);
  assign empty = (occ_q == 4'd0);
  assign count = occ_q;

  assign upd_load     = upd_load_q;
  assign upd_pc       = upd_pc_q;
  assign upd_branched = upd_branched_q;
  assign mispredict   = mispredict_q;
  assign redirect_pc  = redirect_pc_q;

  // Qualify requests and compute next pointers/occupancy.
  always_comb begin
    resolve_ok = resolve && !empty;
    mis        = resolve_ok && (head_pred != resolve_taken);
    // A push alongside a mispredict is on the wrong path and is discarded.
    push_ok    = push && !full && !mis;

    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;

    if (mis) begin
      // Flush: empty the queue by collapsing head onto tail.
      head_d = tail_q;
      occ_d  = 4'd0;
    end else begin
      if (resolve_ok) begin
        head_d = head_q + PtrW'(1);
      end
      if (push_ok) begin
        tail_d = tail_q + PtrW'(1);
      end
      unique case ({push_ok, resolve_ok})
        2'b10:   occ_d = occ_q + 4'd1;
        2'b01:   occ_d = occ_q - 4'd1;
        default: occ_d = occ_q;
      endcase
    end
  end

  // Next values for the registered predictor-update and redirect outputs.
  always_comb begin
    upd_load_d     = resolve_ok;
    mispredict_d   = mis;
    upd_pc_d       = upd_pc_q;
    upd_branched_d = upd_branched_q;
    redirect_pc_d  = redirect_pc_q;
    if (resolve_ok) begin
      upd_pc_d       = head_pc;
      upd_branched_d = resolve_taken;
    end
    if (mis) begin
      // Not-taken fallthrough is the next sequential instruction word.
      redirect_pc_d = resolve_taken ? resolve_target : (head_pc + 16'd2);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 4'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  // Entry write at tail; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      pc_q[tail_q]   <= push_pc;
      pred_q[tail_q] <= push_pred;
    end
  end

  // Output registers; reset also cancels any pending strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      upd_load_q     <= 1'b0;
      upd_pc_q       <= 16'h0000;
      upd_branched_q <= 1'b0;
      mispredict_q   <= 1'b0;
      redirect_pc_q  <= 16'h0000;
    end else begin
      upd_load_q     <= upd_load_d;
      upd_pc_q       <= upd_pc_d;
      upd_branched_q <= upd_branched_d;
      mispredict_q   <= mispredict_d;
      redirect_pc_q  <= redirect_pc_d;
    end
  end

`ifndef SYNTHESIS
  // Sanity properties on internal consistency.
  occ_bounded: assert property (@(posedge clk) disable iff (rst) occ_q <= DepthCnt);
  mis_with_upd: assert property (@(posedge clk) disable iff (rst) mispredict_q |-> upd_load_q);
  ptr_consistent: assert property (@(posedge clk) disable iff (rst)
    (occ_q != DepthCnt) |-> (occ_q[PtrW-1:0] == PtrW'(tail_q - head_q)));
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Scoreboard bench for branch_resolve_queue: a queue-based reference model
// produces expected per-cycle status and update strobes; a monitor compares.
module tb_branch_resolve_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        push;
  logic [15:0] push_pc;
  logic        push_pred;
  logic        resolve;
  logic        resolve_taken;
  logic [15:0] resolve_target;
  logic        full;
  logic        empty;
  logic [3:0]  count;
  logic        upd_load;
  logic [15:0] upd_pc;
  logic        upd_branched;
  logic        mispredict;
  logic [15:0] redirect_pc;

  branch_resolve_queue #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .push           (push),
    .push_pc        (push_pc),
    .push_pred      (push_pred),
    .resolve        (resolve),
    .resolve_taken  (resolve_taken),
    .resolve_target (resolve_target),
    .full           (full),
    .empty          (empty),
    .count          (count),
    .upd_load       (upd_load),
    .upd_pc         (upd_pc),
    .upd_branched   (upd_branched),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic        pred;
  } entry_t;

  typedef struct {
    int          cyc;
    int          cnt;
    logic [15:0] pc;
    logic        br;
    logic [15:0] rd;
  } state_t;

  typedef struct {
    int          cyc;
    logic [15:0] pc;
    logic        br;
    logic        mis;
  } strobe_t;

  entry_t  mq[$];
  state_t  stq[$];
  strobe_t sq[$];

  logic [15:0] l_pc, l_rd;
  logic        l_br;

  int edge_cnt = 0;
  int n_tests  = 0;
  int n_fail   = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got 0x%0h, expected 0x%0h", name, edge_cnt, act, exp);
    end
  endtask

  // Drive one cycle from a negedge and advance the reference model.
  task automatic step(input bit r, input bit p, input logic [15:0] ppc, input bit pp,
                      input bit rs, input bit rt, input logic [15:0] tgt);
    bit      can_push;
    bit      mis;
    entry_t  h;
    strobe_t s;
    state_t  st;
    rst = r; push = p; push_pc = ppc; push_pred = pp;
    resolve = rs; resolve_taken = rt; resolve_target = tgt;
    mis = 1'b0;
    if (r) begin
      mq.delete();
      l_pc = 16'h0; l_br = 1'b0; l_rd = 16'h0;
    end else begin
      can_push = p && (mq.size() < DEPTH);
      if (rs && mq.size() > 0) begin
        h    = mq.pop_front();
        mis  = (h.pred != rt);
        l_pc = h.pc;
        l_br = rt;
        if (mis) l_rd = rt ? tgt : 16'(h.pc + 16'd2);
        s.cyc = edge_cnt + 1; s.pc = h.pc; s.br = rt; s.mis = mis;
        sq.push_back(s);
      end
      if (mis) mq.delete();
      else if (can_push) mq.push_back('{pc: ppc, pred: pp});
    end
    st.cyc = edge_cnt + 1; st.cnt = mq.size(); st.pc = l_pc; st.br = l_br; st.rd = l_rd;
    stq.push_back(st);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic do_push(input logic [15:0] pc, input bit pred);
    step(1'b0, 1'b1, pc, pred, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic do_res(input bit taken, input logic [15:0] tgt);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, taken, tgt);
  endtask

  // Monitor: compare status every covered cycle; pop strobes when presented.
  initial begin
    state_t  st;
    strobe_t s;
    forever begin
      @(posedge clk);
      #1;
      if (stq.size() > 0 && stq[0].cyc == edge_cnt) begin
        st = stq.pop_front();
        chk("count", int'(count), st.cnt);
        chk("empty", int'(empty), int'(st.cnt == 0));
        chk("full", int'(full), int'(st.cnt == DEPTH));
        chk("upd_pc_held", int'(upd_pc), int'(st.pc));
        chk("upd_branched_held", int'(upd_branched), int'(st.br));
        chk("redirect_pc_held", int'(redirect_pc), int'(st.rd));
        if (sq.size() > 0 && sq[0].cyc == edge_cnt) begin
          s = sq.pop_front();
          chk("upd_load", int'(upd_load), 1);
          chk("upd_pc", int'(upd_pc), int'(s.pc));
          chk("upd_branched", int'(upd_branched), int'(s.br));
          chk("mispredict", int'(mispredict), int'(s.mis));
        end else begin
          chk("upd_load_idle", int'(upd_load), 0);
          chk("mispredict_idle", int'(mispredict), 0);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; push = 1'b0; push_pc = 16'h0; push_pred = 1'b0;
    resolve = 1'b0; resolve_taken = 1'b0; resolve_target = 16'h0;
    l_pc = 16'h0; l_br = 1'b0; l_rd = 16'h0;
    @(negedge clk);
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b1, 16'h1234, 1'b1, 1'b1, 1'b1, 16'h0);
    idle();

    // Correct taken prediction.
    do_push(16'h3000, 1'b1);
    do_res(1'b1, 16'h3040);
    idle();

    // Predicted taken, actually not taken: fallthrough redirect.
    do_push(16'h3010, 1'b1);
    do_res(1'b0, 16'h5555);
    idle();

    // Five pushes into four slots, then drain in order.
    for (int i = 0; i < 5; i++) do_push(16'h3100 + 16'(i * 4), 1'b0);
    for (int i = 0; i < 4; i++) do_res(1'b0, 16'h0);
    idle();

    // Three entries, head mispredicts alongside a wrong-path push.
    for (int i = 0; i < 3; i++) do_push(16'h3200 + 16'(i * 2), 1'b0);
    step(1'b0, 1'b1, 16'h3300, 1'b1, 1'b1, 1'b1, 16'h4000);
    idle();

    // Resolve while empty, then full queue with push + correct resolve, then wrap.
    do_res(1'b1, 16'h0);
    for (int i = 0; i < 4; i++) do_push(16'h3400 + 16'(i * 2), 1'b1);
    step(1'b0, 1'b1, 16'h3500, 1'b1, 1'b1, 1'b1, 16'h3600);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 16'h3700 + 16'(i * 2), 1'b1, 1'b1, 1'b1, 16'h0);
    for (int i = 0; i < 4; i++) do_res(1'b1, 16'h0);
    idle();

    // Reset right after a mispredicting resolve.
    do_push(16'h3800, 1'b1);
    do_push(16'h3802, 1'b1);
    do_res(1'b0, 16'h0);
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    idle();

    // Fallthrough wraps at the top of the address space.
    do_push(16'hFFFE, 1'b1);
    do_res(1'b0, 16'h0);
    idle();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) < 6), 16'($urandom) & 16'hFFFE,
           1'($urandom), ($urandom_range(0, 9) < 4), 1'($urandom), 16'($urandom) & 16'hFFFE);
    end
    idle();
    idle();
    @(posedge clk);
    #2;
    chk("strobes_drained", sq.size(), 0);
    chk("states_drained", stq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
